// File: rtl/stage_6_permutation.sv
`default_nettype none
// ============================================================================
//  Module      : stage_6_permutation
//  Description : Registered intra-cycle lane permutation that moves stage-6
//                butterfly partners (lane distance 4) into adjacent lanes.
//                Output lane {o4,o3,o2,o1,o0} takes input lane
//                {o4,o3,o0,o2,o1}. Latency 1 clock; only 32 lanes supported.
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_6_permutation #(
    parameter int DATA_WIDTH_PER_INPUT = 28,
    parameter int INPUT_PER_CYCLE      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_0,  inData_1,  inData_2,  inData_3,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_4,  inData_5,  inData_6,  inData_7,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_8,  inData_9,  inData_10, inData_11,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_12, inData_13, inData_14, inData_15,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_16, inData_17, inData_18, inData_19,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_20, inData_21, inData_22, inData_23,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_24, inData_25, inData_26, inData_27,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_28, inData_29, inData_30, inData_31,
    input  logic                            in_start,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_0,  outData_1,  outData_2,  outData_3,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_4,  outData_5,  outData_6,  outData_7,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_8,  outData_9,  outData_10, outData_11,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_12, outData_13, outData_14, outData_15,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_16, outData_17, outData_18, outData_19,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_20, outData_21, outData_22, outData_23,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_24, outData_25, outData_26, outData_27,
    output logic [DATA_WIDTH_PER_INPUT-1:0] outData_28, outData_29, outData_30, outData_31,
    output logic                            out_start
);

    localparam int c_numLanes = 32;

    logic [DATA_WIDTH_PER_INPUT-1:0] w_inLane  [c_numLanes];
    logic [DATA_WIDTH_PER_INPUT-1:0] r_outLane [c_numLanes];
    logic                            r_outStart;

    // Gather the flat input ports into an indexable lane array
    assign w_inLane[0]  = inData_0;   assign w_inLane[1]  = inData_1;
    assign w_inLane[2]  = inData_2;   assign w_inLane[3]  = inData_3;
    assign w_inLane[4]  = inData_4;   assign w_inLane[5]  = inData_5;
    assign w_inLane[6]  = inData_6;   assign w_inLane[7]  = inData_7;
    assign w_inLane[8]  = inData_8;   assign w_inLane[9]  = inData_9;
    assign w_inLane[10] = inData_10;  assign w_inLane[11] = inData_11;
    assign w_inLane[12] = inData_12;  assign w_inLane[13] = inData_13;
    assign w_inLane[14] = inData_14;  assign w_inLane[15] = inData_15;
    assign w_inLane[16] = inData_16;  assign w_inLane[17] = inData_17;
    assign w_inLane[18] = inData_18;  assign w_inLane[19] = inData_19;
    assign w_inLane[20] = inData_20;  assign w_inLane[21] = inData_21;
    assign w_inLane[22] = inData_22;  assign w_inLane[23] = inData_23;
    assign w_inLane[24] = inData_24;  assign w_inLane[25] = inData_25;
    assign w_inLane[26] = inData_26;  assign w_inLane[27] = inData_27;
    assign w_inLane[28] = inData_28;  assign w_inLane[29] = inData_29;
    assign w_inLane[30] = inData_30;  assign w_inLane[31] = inData_31;

    // One pipeline register per output lane, fed from its fixed source lane
    generate
        for (genvar o = 0; o < c_numLanes; o++) begin : g_lane
            // Source index: keep bits 4:3, move bit 0 up to bit 2, shift bits 2:1 down
            localparam int c_srcLane = (o & 24) | ((o & 1) << 2) | ((o >> 1) & 3);

            // Register the permuted word; reset clears it
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_outLane[o] <= '0;
                end else begin
                    r_outLane[o] <= w_inLane[c_srcLane];
                end
            end
        end
    endgenerate

    // Frame-start marker travels alongside the data with the same latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outStart <= 1'b0;
        end else begin
            r_outStart <= in_start;
        end
    end

    assign out_start = r_outStart;

    assign outData_0  = r_outLane[0];   assign outData_1  = r_outLane[1];
    assign outData_2  = r_outLane[2];   assign outData_3  = r_outLane[3];
    assign outData_4  = r_outLane[4];   assign outData_5  = r_outLane[5];
    assign outData_6  = r_outLane[6];   assign outData_7  = r_outLane[7];
    assign outData_8  = r_outLane[8];   assign outData_9  = r_outLane[9];
    assign outData_10 = r_outLane[10];  assign outData_11 = r_outLane[11];
    assign outData_12 = r_outLane[12];  assign outData_13 = r_outLane[13];
    assign outData_14 = r_outLane[14];  assign outData_15 = r_outLane[15];
    assign outData_16 = r_outLane[16];  assign outData_17 = r_outLane[17];
    assign outData_18 = r_outLane[18];  assign outData_19 = r_outLane[19];
    assign outData_20 = r_outLane[20];  assign outData_21 = r_outLane[21];
    assign outData_22 = r_outLane[22];  assign outData_23 = r_outLane[23];
    assign outData_24 = r_outLane[24];  assign outData_25 = r_outLane[25];
    assign outData_26 = r_outLane[26];  assign outData_27 = r_outLane[27];
    assign outData_28 = r_outLane[28];  assign outData_29 = r_outLane[29];
    assign outData_30 = r_outLane[30];  assign outData_31 = r_outLane[31];

endmodule
`default_nettype wire

// File: tb/tb_stage_6_permutation.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_6_permutation
//  Description : Scoreboard bench for stage_6_permutation. The driver pushes
//                the expected registered output for every issued cycle; a
//                monitor pops and compares one entry per output cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_6_permutation;

    localparam int W = 28;

    typedef logic [31:0][W-1:0] laneVec_t;
    typedef struct packed {
        logic     st;
        laneVec_t d;
    } exp_t;

    // Source lane for each output lane, written out by hand from the lane map
    int srcOf [32] = '{0, 4, 1, 5, 2, 6, 3, 7,
                       8, 12, 9, 13, 10, 14, 11, 15,
                       16, 20, 17, 21, 18, 22, 19, 23,
                       24, 28, 25, 29, 26, 30, 27, 31};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         inStart = 1'b0;
    logic [W-1:0] inArr  [32];
    logic [W-1:0] outArr [32];
    logic         outStart;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    stage_6_permutation #(.DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(32)) dut (
        .clk(clk), .rst(rst), .in_start(inStart), .out_start(outStart),
        .inData_0(inArr[0]),   .inData_1(inArr[1]),   .inData_2(inArr[2]),   .inData_3(inArr[3]),
        .inData_4(inArr[4]),   .inData_5(inArr[5]),   .inData_6(inArr[6]),   .inData_7(inArr[7]),
        .inData_8(inArr[8]),   .inData_9(inArr[9]),   .inData_10(inArr[10]), .inData_11(inArr[11]),
        .inData_12(inArr[12]), .inData_13(inArr[13]), .inData_14(inArr[14]), .inData_15(inArr[15]),
        .inData_16(inArr[16]), .inData_17(inArr[17]), .inData_18(inArr[18]), .inData_19(inArr[19]),
        .inData_20(inArr[20]), .inData_21(inArr[21]), .inData_22(inArr[22]), .inData_23(inArr[23]),
        .inData_24(inArr[24]), .inData_25(inArr[25]), .inData_26(inArr[26]), .inData_27(inArr[27]),
        .inData_28(inArr[28]), .inData_29(inArr[29]), .inData_30(inArr[30]), .inData_31(inArr[31]),
        .outData_0(outArr[0]),   .outData_1(outArr[1]),   .outData_2(outArr[2]),   .outData_3(outArr[3]),
        .outData_4(outArr[4]),   .outData_5(outArr[5]),   .outData_6(outArr[6]),   .outData_7(outArr[7]),
        .outData_8(outArr[8]),   .outData_9(outArr[9]),   .outData_10(outArr[10]), .outData_11(outArr[11]),
        .outData_12(outArr[12]), .outData_13(outArr[13]), .outData_14(outArr[14]), .outData_15(outArr[15]),
        .outData_16(outArr[16]), .outData_17(outArr[17]), .outData_18(outArr[18]), .outData_19(outArr[19]),
        .outData_20(outArr[20]), .outData_21(outArr[21]), .outData_22(outArr[22]), .outData_23(outArr[23]),
        .outData_24(outArr[24]), .outData_25(outArr[25]), .outData_26(outArr[26]), .outData_27(outArr[27]),
        .outData_28(outArr[28]), .outData_29(outArr[29]), .outData_30(outArr[30]), .outData_31(outArr[31])
    );

    function automatic laneVec_t permute(input laneVec_t din);
        laneVec_t r;
        for (int o = 0; o < 32; o++) r[o] = din[srcOf[o]];
        return r;
    endfunction

    function automatic laneVec_t ramp(input int base);
        laneVec_t r;
        for (int j = 0; j < 32; j++) r[j] = W'(base + j);
        return r;
    endfunction

    // Drive one input cycle, then record what the register must hold after the edge
    task automatic step(input logic rv, input logic st, input laneVec_t din);
        exp_t e;
        @(negedge clk);
        rst     = rv;
        inStart = st;
        for (int j = 0; j < 32; j++) inArr[j] = din[j];
        @(posedge clk);
        e.st = rv ? 1'b0 : st;
        e.d  = rv ? '0 : permute(din);
        q.push_back(e);
    endtask

    // Monitor: one expected entry per output cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (outStart !== e.st) begin
                errors++;
                $display("FAIL out_start t=%0t got=%b want=%b", $time, outStart, e.st);
            end
            for (int o = 0; o < 32; o++) begin
                checks++;
                if (outArr[o] !== e.d[o]) begin
                    errors++;
                    $display("FAIL outData_%0d t=%0t got=%h want=%h", o, $time, outArr[o], e.d[o]);
                end
            end
        end
    end

    initial begin
        laneVec_t ones;
        laneVec_t mixed;
        laneVec_t pattern0;
        ones = '1;
        for (int j = 0; j < 32; j++) mixed[j] = W'((j + 1) * 32'h9E37 ^ 32'hA5C3E1);

        // Hand-written check of the lane map for inData_j = j
        pattern0 = permute(ramp(0));
        checks++;
        if (pattern0[1] !== W'(4) || pattern0[2] !== W'(1) || pattern0[9] !== W'(12) ||
            pattern0[30] !== W'(27)) begin
            errors++;
            $display("FAIL laneMap got=%0d,%0d,%0d,%0d want=4,1,12,27",
                     pattern0[1], pattern0[2], pattern0[9], pattern0[30]);
        end

        for (int j = 0; j < 32; j++) inArr[j] = '1;

        // Reset held two cycles with garbage inputs and a start pulse
        step(1'b1, 1'b1, ones);
        step(1'b1, 1'b1, mixed);

        // Single frame start with inData_j = j, then idle
        step(1'b0, 1'b1, ramp(0));
        step(1'b0, 1'b0, '0);

        // 32-cycle continuous stream, start only on the first cycle
        for (int k = 0; k < 32; k++) step(1'b0, (k == 0), ramp(32 * k));

        // Mid-stream reset for one cycle, then resume
        step(1'b0, 1'b1, ramp(1000));
        step(1'b1, 1'b0, ramp(2000));
        step(1'b0, 1'b0, ramp(3000));
        step(1'b0, 1'b0, mixed);

        // Back-to-back start pulses
        step(1'b0, 1'b1, ramp(500));
        step(1'b0, 1'b1, ramp(600));
        step(1'b0, 1'b0, ramp(700));

        // All-ones words pass through unmodified
        step(1'b0, 1'b0, ones);
        step(1'b0, 1'b0, '0);

        // Drain
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0 pending entries", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
